// File: rtl/rtc_bus_sequencer.sv
// rtc_bus_sequencer: drives a multiplexed-bus RTC chip (address phase, then data phase).
// Host read/write requests have priority; when idle with poll_en set, the RTC registers
// are read round-robin into a shadow bank.
//
// Ports:
//   clk, reset            - system clock, asynchronous active-low reset
//   req_valid/req_ready   - host request handshake (accepted when both high)
//   req_write/addr/wdata  - host request attributes, latched on acceptance
//   poll_en               - enables autonomous round-robin polling
//   rd_valid, rd_data     - host read completion pulse and captured data
//   regs                  - shadow register bank, register i at [i*DW +: DW]
//   cs_n, rd_n, wr_n, aod - RTC control strobes (active low) and address/data select
//   bus_dout, bus_oe      - outgoing bus value and drive enable (tristate at top level)
//   bus_din               - incoming bus value
//   busy                  - FSM outside IDLE
module rtc_bus_sequencer #(
    parameter int unsigned DW       = 8,
    parameter int unsigned NREG     = 11,
    parameter int unsigned REG_BASE = 'h21,
    parameter int unsigned T_PHASE  = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    input  logic               req_write,
    input  logic [DW-1:0]      req_addr,
    input  logic [DW-1:0]      req_wdata,
    output logic               req_ready,
    input  logic               poll_en,
    output logic               rd_valid,
    output logic [DW-1:0]      rd_data,
    output logic [NREG*DW-1:0] regs,
    output logic               cs_n,
    output logic               rd_n,
    output logic               wr_n,
    output logic               aod,
    output logic [DW-1:0]      bus_dout,
    output logic               bus_oe,
    input  logic [DW-1:0]      bus_din,
    output logic               busy
);

    localparam int unsigned    IW      = (NREG > 1) ? $clog2(NREG) : 1;
    localparam logic [DW-1:0]  BASE    = DW'(REG_BASE);
    localparam logic [7:0]     PH_LAST = 8'(T_PHASE - 1);

    // Elaboration-time parameter checks.
    if (T_PHASE < 1 || T_PHASE > 255) begin : g_bad_tphase
        $error("rtc_bus_sequencer: T_PHASE must be in 1..255");
    end
    if (DW < 1 || DW > 32) begin : g_bad_dw
        $error("rtc_bus_sequencer: DW must be in 1..32");
    end
    if (NREG < 1 || (64'(REG_BASE) + 64'(NREG) - 64'd1) > ((64'd1 << DW) - 64'd1)) begin : g_bad_map
        $error("rtc_bus_sequencer: register window exceeds the address space");
    end

    typedef enum logic [2:0] {
        StIdle,
        StAddrSetup,
        StAddrStrobe,
        StAddrHold,
        StDataSetup,
        StDataStrobe,
        StDataHold
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        phase_q, phase_d;
    logic              is_write_q;
    logic              is_poll_q;
    logic [DW-1:0]     addr_q;
    logic [DW-1:0]     wdata_q;
    logic [DW-1:0]     rsamp_q;
    logic [IW-1:0]     poll_idx_q;
    logic [DW-1:0]     rd_data_q;
    logic              rd_valid_q;
    logic [NREG*DW-1:0] regs_q;

    logic              phase_last;
    logic              host_go;
    logic              poll_go;
    logic              done;
    logic [DW-1:0]     poll_addr;
    logic [DW-1:0]     offset;
    logic              in_range;

    assign phase_last = (phase_q == PH_LAST);
    assign host_go    = (state_q == StIdle) && req_valid;
    assign poll_go    = (state_q == StIdle) && !req_valid && poll_en;
    assign done       = (state_q == StDataHold) && phase_last;
    assign poll_addr  = BASE + DW'(poll_idx_q);
    // Modulo subtraction: addresses below BASE wrap high and fall out of range.
    assign offset     = addr_q - BASE;
    assign in_range   = (32'(offset) < NREG);

    assign req_ready = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign regs      = regs_q;

    // State register and phase counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            phase_q <= 8'd0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
        end
    end

    // Next-state: every non-idle state lasts exactly T_PHASE cycles.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        if (state_q == StIdle) begin
            phase_d = 8'd0;
            if (host_go || poll_go) begin
                state_d = StAddrSetup;
            end
        end else if (phase_last) begin
            phase_d = 8'd0;
            unique case (state_q)
                StAddrSetup:  state_d = StAddrStrobe;
                StAddrStrobe: state_d = StAddrHold;
                StAddrHold:   state_d = StDataSetup;
                StDataSetup:  state_d = StDataStrobe;
                StDataStrobe: state_d = StDataHold;
                StDataHold:   state_d = StIdle;
                default:      state_d = StIdle;
            endcase
        end else begin
            phase_d = phase_q + 8'd1;
        end
    end

    // Bus outputs decoded straight from state so reset releases them immediately.
    always_comb begin
        cs_n     = 1'b1;
        rd_n     = 1'b1;
        wr_n     = 1'b1;
        aod      = 1'b0;
        bus_oe   = 1'b0;
        bus_dout = '0;
        unique case (state_q)
            StIdle: begin
            end
            StAddrSetup, StAddrHold: begin
                cs_n     = 1'b0;
                bus_oe   = 1'b1;
                bus_dout = addr_q;
            end
            StAddrStrobe: begin
                cs_n     = 1'b0;
                bus_oe   = 1'b1;
                bus_dout = addr_q;
                wr_n     = 1'b0;
            end
            StDataSetup, StDataHold: begin
                cs_n = 1'b0;
                aod  = 1'b1;
                if (is_write_q) begin
                    bus_oe   = 1'b1;
                    bus_dout = wdata_q;
                end
            end
            StDataStrobe: begin
                cs_n = 1'b0;
                aod  = 1'b1;
                if (is_write_q) begin
                    bus_oe   = 1'b1;
                    bus_dout = wdata_q;
                    wr_n     = 1'b0;
                end else begin
                    rd_n = 1'b0;
                end
            end
            default: begin
            end
        endcase
    end

    // Transaction latches, read sampling and completion side effects.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            is_write_q <= 1'b0;
            is_poll_q  <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rsamp_q    <= '0;
            poll_idx_q <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            regs_q     <= '0;
        end else begin
            rd_valid_q <= 1'b0;
            if (host_go) begin
                is_write_q <= req_write;
                is_poll_q  <= 1'b0;
                addr_q     <= req_addr;
                wdata_q    <= req_wdata;
            end else if (poll_go) begin
                is_write_q <= 1'b0;
                is_poll_q  <= 1'b1;
                addr_q     <= poll_addr;
            end
            if ((state_q == StDataStrobe) && phase_last && !is_write_q) begin
                rsamp_q <= bus_din;
            end
            if (done) begin
                if (in_range) begin
                    for (int i = 0; i < NREG; i++) begin
                        if (offset == DW'(i)) begin
                            regs_q[i*DW +: DW] <= is_write_q ? wdata_q : rsamp_q;
                        end
                    end
                end
                if (is_poll_q) begin
                    poll_idx_q <= (poll_idx_q == IW'(NREG - 1)) ? '0 : poll_idx_q + IW'(1);
                end else if (!is_write_q) begin
                    rd_data_q  <= rsamp_q;
                    rd_valid_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Directed testbench for rtc_bus_sequencer. Two instances share clock and reset:
// dut_a (NREG=11, T_PHASE=2) for host transactions and reset abort,
// dut_b (NREG=3,  T_PHASE=2) for round-robin polling with a bus model returning addr+1.
module tb_rtc_bus_sequencer;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    // dut_a signals
    logic        req_valid_a = 1'b0, req_write_a = 1'b0;
    logic [7:0]  req_addr_a = '0, req_wdata_a = '0, bus_din_a = '0;
    logic        req_ready_a, rd_valid_a, cs_n_a, rd_n_a, wr_n_a, aod_a, bus_oe_a, busy_a;
    logic [7:0]  rd_data_a, bus_dout_a;
    logic [87:0] regs_a;

    // dut_b signals
    logic        req_valid_b = 1'b0, req_write_b = 1'b0, poll_en_b = 1'b0;
    logic [7:0]  req_addr_b = '0, req_wdata_b = '0, bus_din_b;
    logic        req_ready_b, rd_valid_b, cs_n_b, rd_n_b, wr_n_b, aod_b, bus_oe_b, busy_b;
    logic [7:0]  rd_data_b, bus_dout_b;
    logic [23:0] regs_b;

    rtc_bus_sequencer #(.DW(8), .NREG(11), .REG_BASE('h21), .T_PHASE(2)) dut_a (
        .clk(clk), .reset(reset),
        .req_valid(req_valid_a), .req_write(req_write_a), .req_addr(req_addr_a),
        .req_wdata(req_wdata_a), .req_ready(req_ready_a), .poll_en(1'b0),
        .rd_valid(rd_valid_a), .rd_data(rd_data_a), .regs(regs_a),
        .cs_n(cs_n_a), .rd_n(rd_n_a), .wr_n(wr_n_a), .aod(aod_a),
        .bus_dout(bus_dout_a), .bus_oe(bus_oe_a), .bus_din(bus_din_a), .busy(busy_a)
    );

    rtc_bus_sequencer #(.DW(8), .NREG(3), .REG_BASE('h21), .T_PHASE(2)) dut_b (
        .clk(clk), .reset(reset),
        .req_valid(req_valid_b), .req_write(req_write_b), .req_addr(req_addr_b),
        .req_wdata(req_wdata_b), .req_ready(req_ready_b), .poll_en(poll_en_b),
        .rd_valid(rd_valid_b), .rd_data(rd_data_b), .regs(regs_b),
        .cs_n(cs_n_b), .rd_n(rd_n_b), .wr_n(wr_n_b), .aod(aod_b),
        .bus_dout(bus_dout_b), .bus_oe(bus_oe_b), .bus_din(bus_din_b), .busy(busy_b)
    );

    // RTC model for dut_b: remembers the address phase, returns address+1 on reads.
    logic [7:0] model_addr_b = '0;
    logic       cs_prev_b = 1'b1;
    logic [7:0] addr_log [16];
    int         n_log = 0;
    assign bus_din_b = model_addr_b + 8'd1;

    always @(posedge clk) begin
        if (!cs_n_b && !aod_b) model_addr_b <= bus_dout_b;
        cs_prev_b <= cs_n_b;
        if (cs_prev_b && !cs_n_b && n_log < 16) begin
            addr_log[n_log] <= bus_dout_b;
            n_log <= n_log + 1;
        end
    end

    int n_vec = 0;
    int n_err = 0;
    logic [87:0] exp_a = '0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for dut_b to start (if idle) and then finish a transaction.
    task automatic wait_done_b(input string tag);
        int n = 0;
        while (!busy_b && n < 100) begin tick(); n++; end
        while (busy_b && n < 100) begin tick(); n++; end
        check(tag, 128'(n < 100), 128'(1));
    endtask

    initial begin
        int cnt;
        logic exp_wr_n, exp_aod;
        logic [7:0] exp_dout;

        // Reset state
        repeat (3) tick();
        check("rst_strobes", {cs_n_a, rd_n_a, wr_n_a, aod_a, bus_oe_a}, 5'b11100);
        check("rst_bus_dout", bus_dout_a, 8'h00);
        check("rst_busy_ready", {busy_a, req_ready_a}, 2'b01);
        check("rst_rd", {rd_valid_a, rd_data_a}, 9'h000);
        check("rst_regs", regs_a, 88'h0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Host write 0x21 <- 0x45, cycle-by-cycle
        req_valid_a = 1'b1; req_write_a = 1'b1; req_addr_a = 8'h21; req_wdata_a = 8'h45;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 1) req_valid_a = 1'b0;
            exp_wr_n = !(k == 3 || k == 4 || k == 9 || k == 10);
            exp_aod  = (k > 6);
            exp_dout = (k <= 6) ? 8'h21 : 8'h45;
            check($sformatf("wr_cycle%0d", k), {cs_n_a, rd_n_a, wr_n_a, aod_a, bus_oe_a, bus_dout_a},
                  {1'b0, 1'b1, exp_wr_n, exp_aod, 1'b1, exp_dout});
        end
        tick();
        exp_a[7:0] = 8'h45;
        check("wr_idle", {cs_n_a, busy_a, rd_valid_a}, 3'b100);
        check("wr_regs", regs_a, exp_a);

        // Host read 0x23, bus returns 0x59
        bus_din_a = 8'h59;
        req_valid_a = 1'b1; req_write_a = 1'b0; req_addr_a = 8'h23;
        cnt = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 1) req_valid_a = 1'b0;
            if (!rd_n_a) cnt++;
            if (k == 9) check("rd_strobe_oe", {rd_n_a, wr_n_a, aod_a, bus_oe_a}, 4'b0110);
        end
        check("rd_n_len", cnt, 2);
        tick();
        exp_a[23:16] = 8'h59;
        check("rd_valid_pulse", {rd_valid_a, rd_data_a}, {1'b1, 8'h59});
        check("rd_regs", regs_a, exp_a);
        bus_din_a = 8'h00;
        tick();
        check("rd_valid_single", {rd_valid_a, rd_data_a}, {1'b0, 8'h59});

        // Out-of-range write 0x40: full cycle, regs untouched
        req_valid_a = 1'b1; req_write_a = 1'b1; req_addr_a = 8'h40; req_wdata_a = 8'hAA;
        tick();
        req_valid_a = 1'b0;
        cnt = 0;
        while (busy_a && cnt < 100) begin cnt++; tick(); end
        check("oor_busy_len", cnt, 12);
        check("oor_regs", regs_a, exp_a);

        // Highest in-range address 0x2B
        req_valid_a = 1'b1; req_write_a = 1'b1; req_addr_a = 8'h2B; req_wdata_a = 8'h5C;
        tick();
        req_valid_a = 1'b0;
        cnt = 0;
        while (busy_a && cnt < 100) begin cnt++; tick(); end
        exp_a[87:80] = 8'h5C;
        check("top_busy_len", cnt, 12);
        check("top_regs", regs_a, exp_a);

        // Reset during DATA_STROBE of a write
        req_valid_a = 1'b1; req_write_a = 1'b1; req_addr_a = 8'h22; req_wdata_a = 8'h77;
        tick();
        req_valid_a = 1'b0;
        repeat (8) tick();
        check("abort_pre", {cs_n_a, wr_n_a, aod_a, bus_oe_a}, 4'b0011);
        reset = 1'b0;
        #1;
        check("abort_strobes", {cs_n_a, wr_n_a, rd_n_a, bus_oe_a, aod_a}, 5'b11100);
        check("abort_busy", {busy_a, req_ready_a, bus_dout_a}, {2'b01, 8'h00});
        @(negedge clk);
        reset = 1'b1;
        repeat (3) tick();
        exp_a = '0;
        check("abort_regs", regs_a, exp_a);
        check("abort_idle", busy_a, 1'b0);

        // Polling on dut_b
        poll_en_b = 1'b1;
        wait_done_b("poll1_timeout");
        wait_done_b("poll2_timeout");
        wait_done_b("poll3_timeout");
        check("poll3_regs", regs_b, {8'h24, 8'h23, 8'h22});
        check("poll_no_rd_valid", rd_valid_b, 1'b0);
        wait_done_b("poll4_timeout");
        tick();
        check("poll5_busy", busy_b, 1'b1);
        // Host request arrives while the index-1 poll is in flight
        req_valid_b = 1'b1; req_write_b = 1'b1; req_addr_b = 8'h21; req_wdata_b = 8'h99;
        wait_done_b("poll5_timeout");
        tick();
        req_valid_b = 1'b0;
        wait_done_b("host_b_timeout");
        check("host_b_regs", regs_b, {8'h24, 8'h23, 8'h99});
        wait_done_b("poll7_timeout");
        tick();
        poll_en_b = 1'b0;
        wait_done_b("poll8_timeout");
        check("poll8_regs", regs_b, {8'h24, 8'h23, 8'h22});
        cnt = 0;
        repeat (20) begin tick(); if (busy_b) cnt++; end
        check("poll_stopped", cnt, 0);
        check("log_count", n_log, 8);
        check("log_order", {addr_log[0], addr_log[1], addr_log[2], addr_log[3],
                            addr_log[4], addr_log[5], addr_log[6], addr_log[7]},
              64'h21_22_23_21_22_21_23_21);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rtc_bus_sequencer.md
RTC_BUS_SEQUENCER -- requirements
Module: rtc_bus_sequencer

Interface
REQ-001 Parameter DW, default 8: bus and register data width.
REQ-002 Parameter NREG, default 11: number of shadowed RTC registers.
REQ-003 Parameter REG_BASE, default 8'h21: bus address of shadow register 0; register i is at REG_BASE+i.
REQ-004 Parameter T_PHASE, default 4, legal range 1..255: clock cycles per bus phase.
REQ-005 clk  in  1  single system clock; all logic on its rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 req_valid  in  1  host transaction request.
REQ-008 req_write  in  1  1 = write, 0 = read; sampled with req_valid.
REQ-009 req_addr, req_wdata  in  DW each  host address and write data.
REQ-010 req_ready  out  1  sequencer can accept a host request.
REQ-011 poll_en  in  1  enables autonomous round-robin read polling.
REQ-012 rd_valid  out  1  one-cycle pulse marking completion of a host read.
REQ-013 rd_data  out  DW  data captured by the last host read.
REQ-014 regs  out  NREG*DW  shadow register bank; register i occupies bits [i*DW +: DW].
REQ-015 cs_n, rd_n, wr_n  out  1 each  active-low RTC chip-select, read strobe and write strobe.
REQ-016 aod  out  1  RTC address/data select; 0 = address phase, 1 = data phase.
REQ-017 bus_dout  out  DW  value driven onto the multiplexed bus.
REQ-018 bus_oe  out  1  bus drive enable; the tristate buffer lives at top level.
REQ-019 bus_din  in  DW  value sampled from the multiplexed bus.
REQ-020 busy  out  1  high whenever the FSM is outside IDLE.

Function
REQ-021 FSM states: IDLE, ADDR_SETUP, ADDR_STROBE, ADDR_HOLD, DATA_SETUP, DATA_STROBE, DATA_HOLD.
REQ-022 Each non-IDLE state shall last exactly T_PHASE cycles, timed by a phase counter.
- After the last cycle the FSM advances to the next state in the listed order.
- DATA_HOLD returns to IDLE.
REQ-023 IDLE shall last at least one cycle between transactions.
- One full transaction is 6*T_PHASE busy cycles.
REQ-024 Outputs per state:
- IDLE: cs_n=1, rd_n=1, wr_n=1, aod=0, bus_oe=0.
- All non-IDLE states: cs_n=0.
- ADDR_*: aod=0, bus_oe=1, bus_dout=latched address.
- ADDR_STROBE: wr_n=0.
- DATA_*: aod=1.
- DATA_* on write: bus_oe=1, bus_dout=latched write data.
- DATA_* on read: bus_oe=0.
- DATA_STROBE: wr_n=0 on write, rd_n=0 on read.
REQ-025 req_ready shall be high only in IDLE.
- A host transaction is accepted on a cycle with req_valid and req_ready both high.
- req_write, req_addr and req_wdata are latched on that cycle.
REQ-026 Request arbitration in IDLE:
- A host request has priority over polling.
- If no host request is present and poll_en=1, a poll read starts at REG_BASE+poll_idx.
REQ-027 poll_idx shall advance only when a poll read completes.
- It wraps from NREG-1 to 0.
- A host request that preempts a poll leaves poll_idx unchanged.
REQ-028 Read data shall be sampled from bus_din on the last cycle of DATA_STROBE.
REQ-029 On completion of a read (poll or host) to an address in REG_BASE..REG_BASE+NREG-1, the matching regs entry shall update on the DATA_HOLD->IDLE transition.
REQ-030 On completion of a host write to an in-range address, the matching regs entry shall be updated with the written data.
REQ-031 Out-of-range host addresses shall run a full bus cycle but shall leave regs unchanged.
REQ-032 Host read completion:
- rd_valid pulses for exactly one cycle, coincident with the first IDLE cycle.
- rd_data holds the sampled value until the next host read completes.
REQ-033 Deasserting poll_en mid-transaction shall let the current transaction complete; no new poll starts afterwards.
REQ-034 Address arithmetic shall be DW-bit modulo; REG_BASE+NREG-1 must not exceed 2^DW-1 (parameter check).

Reset
REQ-035 While reset=0, asynchronously:
- State = IDLE and the phase counter = 0.
- poll_idx = 0 and all regs = 0.
- rd_data = 0 and rd_valid = 0.
- cs_n = rd_n = wr_n = 1, aod = 0, bus_oe = 0, bus_dout = 0.
- busy = 0 and req_ready = 1.
REQ-036 Reset asserted mid-transaction shall release all strobes and the bus immediately; the aborted transaction shall update nothing.

Verification
REQ-037 Host write, T_PHASE=2, addr 8'h21, data 8'h45 -> the following response is required:
- cs_n low for 12 cycles; aod=0 for 6 cycles, then 1 for 6 cycles.
- wr_n low in cycles 3-4 and 9-10; bus_dout=8'h21, then 8'h45.
- regs[7:0]=8'h45 afterwards.
REQ-038 Host read of 8'h23 with bus_din=8'h59 during DATA_STROBE -> rd_valid single pulse, rd_data=8'h59, regs[23:16]=8'h59, rd_n low 2 cycles.
REQ-039 poll_en=1, NREG=3, bus model returns addr+1 -> reads in order 8'h21, 8'h22, 8'h23, 8'h21; regs = {8'h24, 8'h23, 8'h22}.
REQ-040 req_valid asserted while poll_idx=1 and a poll is in flight -> poll completes first, then the host cycle runs, then polling resumes at index 2.
REQ-041 reset driven low in DATA_STROBE of a write -> cs_n, wr_n and bus_oe return to 1/1/0 in the same cycle; regs remain 0.
REQ-042 Host write to 8'h40 with NREG=11 -> full 6*T_PHASE bus cycle; regs unchanged.
